// File: rtl/zpu_vdisk_bridge.sv
// Bridge between the ZPU disk firmware ports and the hps_io virtual-disk interface.
// Holds the sector buffer, the block request/ack FSM with timeout and the per-drive mount-event queue.
module zpu_vdisk_bridge #(
    parameter int               VDNUM   = 3,
    parameter int               BUF_AW  = 9,
    parameter int               TMO_W   = 24,
    parameter logic [VDNUM-1:0] RO_MASK = 3'b100
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic [31:0]       zpu_out2_i,
    input  logic [31:0]       zpu_out3_i,
    input  logic              zpu_data_wr_i,
    input  logic              zpu_data_rd_i,
    input  logic              zpu_io_wr_i,
    output logic [15:0]       zpu_in2_o,
    output logic [31:0]       zpu_in3_o,
    input  logic [1:0]        file_type_i,
    output logic [31:0]       sd_lba_o,
    output logic [VDNUM-1:0]  sd_rd_o,
    output logic [VDNUM-1:0]  sd_wr_o,
    input  logic              sd_ack_i,
    input  logic [BUF_AW-1:0] sd_buff_addr_i,
    input  logic [7:0]        sd_buff_dout_i,
    output logic [7:0]        sd_buff_din_o,
    input  logic              sd_buff_wr_i,
    input  logic [VDNUM-1:0]  img_mounted_i,
    input  logic              img_readonly_i,
    input  logic [63:0]       img_size_i
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST   = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]       GAP_RELOAD = 4'd15;

    logic              lba_sel;
    logic [2:0]        drv;
    logic              drv_ok;
    logic              rd_rise, wr_rise, ack_fall, zrd_fall;
    logic [VDNUM-1:0]  mnt_rise;
    logic              unused_bits;

    logic [7:0]        buf_mem [2**BUF_AW];
    logic [1:0]        zwr_q;
    logic              zwr_edge_q, ptr_inc_q, zrd_q;
    logic [BUF_AW-1:0] ptr_q;
    logic [31:0]       lba_q;
    logic [7:0]        zpu_byte_q, hps_byte_q;

    state_t            state_q, state_d;
    logic [VDNUM-1:0]  sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic              done_q, done_d, err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        blk_q;
    logic              ack_q;

    logic [VDNUM-1:0]  mnt_q, pend_q, pend_d;
    logic              ro_lat_q [VDNUM];
    logic [31:0]       size_lat_q [VDNUM];
    logic [3:0]        gap_q, gap_d;
    logic              toggle_q, toggle_d, ro_q, ro_d;
    logic [2:0]        fileno_q, fileno_d, pop_sel;
    logic [1:0]        ftype_q, ftype_d;
    logic [31:0]       fsize_q, fsize_d, pop_size;
    logic              pop_ro;

    assign lba_sel     = zpu_out2_i[0];
    assign drv         = zpu_out2_i[5:3];
    assign drv_ok      = int'(drv) < VDNUM;
    assign rd_rise     = zpu_out2_i[1] & ~blk_q[0];
    assign wr_rise     = zpu_out2_i[2] & ~blk_q[1];
    assign ack_fall    = ack_q & ~sd_ack_i;
    assign zrd_fall    = zrd_q & ~zpu_data_rd_i;
    assign mnt_rise    = img_mounted_i & ~mnt_q;
    assign unused_bits = ^{zpu_out2_i[31:6], img_size_i[63:32]};

    // Buffer storage carries no reset; both ports write, hps_io wins on a same-address clash.
    always_ff @(posedge clk_sys_i) begin
        if (zwr_edge_q && !lba_sel) buf_mem[ptr_q] <= zpu_out3_i[7:0];
        if (sd_buff_wr_i)           buf_mem[sd_buff_addr_i] <= sd_buff_dout_i;
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            zwr_q      <= '0;
            zwr_edge_q <= 1'b0;
            ptr_inc_q  <= 1'b0;
            zrd_q      <= 1'b0;
            ptr_q      <= '0;
            lba_q      <= '0;
            zpu_byte_q <= '0;
            hps_byte_q <= '0;
        end else begin
            zwr_q      <= {zwr_q[0], zpu_data_wr_i};
            zwr_edge_q <= zwr_q[0] & ~zwr_q[1];
            ptr_inc_q  <= zwr_edge_q & ~lba_sel;
            zrd_q      <= zpu_data_rd_i;
            zpu_byte_q <= buf_mem[ptr_q];
            hps_byte_q <= buf_mem[sd_buff_addr_i];
            if (zwr_edge_q && lba_sel) lba_q <= zpu_out3_i;
            if (zpu_io_wr_i) ptr_q <= '0;
            else             ptr_q <= ptr_q + BUF_AW'(ptr_inc_q) + BUF_AW'(zrd_fall);
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sd_rd_q <= '0;
            sd_wr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            blk_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            blk_q   <= zpu_out2_i[2:1];
            ack_q   <= sd_ack_i;
        end
    end

    always_comb begin
        state_d = state_q;
        sd_rd_d = sd_rd_q;
        sd_wr_d = sd_wr_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_rise || wr_rise) begin
                    if (drv_ok) begin
                        if (rd_rise) sd_rd_d = VDNUM'(1) << drv;
                        else         sd_wr_d = VDNUM'(1) << drv;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        tmo_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Ack wins over a timeout landing in the same cycle.
                if (sd_ack_i) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = ST_XFER;
                end else if (tmo_q == TMO_LAST) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (ack_fall) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d   = pend_q | mnt_rise;
        gap_d    = gap_q;
        toggle_d = toggle_q;
        fileno_d = fileno_q;
        ftype_d  = ftype_q;
        ro_d     = ro_q;
        fsize_d  = fsize_q;
        pop_sel  = '0;
        pop_ro   = 1'b0;
        pop_size = '0;
        for (int i = VDNUM - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pop_sel  = 3'(i);
                pop_ro   = ro_lat_q[i] | RO_MASK[i];
                pop_size = size_lat_q[i];
            end
        end
        // The holdoff keeps each toggle visible long enough for the firmware poll loop.
        if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else if (pend_q != '0) begin
            gap_d    = GAP_RELOAD;
            toggle_d = ~toggle_q;
            fileno_d = pop_sel;
            ftype_d  = file_type_i;
            ro_d     = pop_ro;
            fsize_d  = pop_size;
            pend_d   = (pend_q & ~(VDNUM'(1) << pop_sel)) | mnt_rise;
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            mnt_q    <= '0;
            pend_q   <= '0;
            gap_q    <= '0;
            toggle_q <= 1'b0;
            fileno_q <= '0;
            ftype_q  <= '0;
            ro_q     <= 1'b0;
            fsize_q  <= '0;
            for (int i = 0; i < VDNUM; i++) begin
                ro_lat_q[i]   <= 1'b0;
                size_lat_q[i] <= '0;
            end
        end else begin
            mnt_q    <= img_mounted_i;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
            toggle_q <= toggle_d;
            fileno_q <= fileno_d;
            ftype_q  <= ftype_d;
            ro_q     <= ro_d;
            fsize_q  <= fsize_d;
            for (int i = 0; i < VDNUM; i++) begin
                if (mnt_rise[i]) begin
                    ro_lat_q[i]   <= img_readonly_i;
                    size_lat_q[i] <= img_size_i[31:0];
                end
            end
        end
    end

    assign zpu_in2_o     = {7'd0, err_q, ro_q, ftype_q, fileno_q, toggle_q, done_q};
    assign zpu_in3_o     = lba_sel ? fsize_q : {24'd0, zpu_byte_q};
    assign sd_lba_o      = lba_q;
    assign sd_rd_o       = sd_rd_q;
    assign sd_wr_o       = sd_wr_q;
    assign sd_buff_din_o = hps_byte_q;

endmodule
